// File: rtl/disp_arbiter.sv
// Two-requester 4-digit seven-segment display arbiter: round-robin grant held
// for at least HOLD complete scan frames, with the shown value snapshotted per frame.
module disp_arbiter #(
  parameter int DIV  = 50000,
  parameter int HOLD = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_a,
  input  logic        req_b,
  input  logic [15:0] val_a,
  input  logic [15:0] val_b,
  input  logic        sign_a,
  input  logic        sign_b,
  output logic        gnt_a,
  output logic        gnt_b,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        frame_done
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int HW = $clog2(HOLD + 1) + 1;

  typedef enum logic [1:0] {IDLE, SHOW_A, SHOW_B} state_t;

  state_t          state, state_n;
  logic [PW-1:0]   presc;
  logic [1:0]      idx;
  logic [HW-1:0]   hold, hold_inc;
  logic [16:0]     lat, lat_src;
  logic            tick, frame_end, held, restart, load;
  logic [3:0]      digit;

  assign tick      = (presc == PW'(DIV - 1));
  assign frame_end = (state != IDLE) && tick && (idx == 2'd3);
  assign hold_inc  = (hold >= HW'(HOLD)) ? hold : hold + HW'(1);
  assign held      = (hold_inc >= HW'(HOLD));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (req_a)      state_n = SHOW_A;
        else if (req_b) state_n = SHOW_B;
      end
      SHOW_A: begin
        if (frame_end && held) begin
          if (req_b)       state_n = SHOW_B;
          else if (!req_a) state_n = IDLE;
        end
      end
      SHOW_B: begin
        if (frame_end && held) begin
          if (req_a)       state_n = SHOW_A;
          else if (!req_b) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Any state change (grant, switch, release) restarts the scan from digit 0.
  assign restart = (state_n != state);
  assign load    = (state_n != IDLE) && (restart || frame_end);
  assign lat_src = (state_n == SHOW_A) ? {sign_a, val_a} : {sign_b, val_b};
  assign digit   = lat[{idx, 2'b00} +: 4];

  function automatic logic [6:0] hex7(input logic [3:0] d);
    case (d)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      presc      <= '0;
      idx        <= '0;
      hold       <= '0;
      lat        <= '0;
      gnt_a      <= 1'b0;
      gnt_b      <= 1'b0;
      an         <= 4'b1111;
      seg        <= 7'b1111111;
      frame_done <= 1'b0;
    end else begin
      gnt_a      <= (state_n == SHOW_A);
      gnt_b      <= (state_n == SHOW_B);
      frame_done <= frame_end;
      if (restart || state == IDLE) begin
        presc <= '0;
        idx   <= '0;
        hold  <= '0;
      end else begin
        presc <= tick ? '0 : presc + PW'(1);
        if (tick)      idx  <= idx + 2'd1;
        if (frame_end) hold <= hold_inc;
      end
      if (load) lat <= lat_src;
      // Display follows the registered index, so it lags the index by one clock.
      if (state == IDLE) begin
        an  <= 4'b1111;
        seg <= 7'b1111111;
      end else begin
        an  <= ~(4'b0001 << idx);
        seg <= (lat[16] && idx == 2'd3) ? 7'b0111111 : hex7(digit);
      end
    end
  end

endmodule

// File: tb/tb_disp_arbiter.sv
// Bench for disp_arbiter: cycle-accurate arithmetic reference model checked every
// cycle, plus directed literal checks of scan order, hold length and reset.
module tb_disp_arbiter;
  localparam int DIV   = 4;
  localparam int HOLD  = 2;
  localparam int FRAME = 4 * DIV;

  logic        clk = 1'b0;
  logic        rst, req_a, req_b, sign_a, sign_b;
  logic [15:0] val_a, val_b;
  logic        gnt_a, gnt_b, frame_done;
  logic [3:0]  an;
  logic [6:0]  seg;

  int total = 0;
  int bad   = 0;

  disp_arbiter #(.DIV(DIV), .HOLD(HOLD)) dut (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b),
    .val_a(val_a), .val_b(val_b), .sign_a(sign_a), .sign_b(sign_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .an(an), .seg(seg), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  task automatic chk(input string nm, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
    end
  endtask

  // Reference model: mode 0=idle 1=A 2=B; t = cycles since grant.
  int          m_mode = 0, m_t = 0, m_fr = 0;
  logic [16:0] m_lat = '0;
  logic        e_ok = 1'b0, e_ga, e_gb, e_fd;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;

  function automatic logic [16:0] pick(input int who);
    return (who == 1) ? {sign_a, val_a} : {sign_b, val_b};
  endfunction

  always @(posedge clk) begin
    int  d;
    bit  fe, cur, oth;
    d  = (m_t / DIV) % 4;
    fe = (m_mode != 0) && (m_t % FRAME == FRAME - 1);
    if (m_mode == 0) begin
      e_an = 4'hF; e_seg = 7'h7F;
    end else begin
      e_an  = ~(4'h1 << d);
      e_seg = (d == 3 && m_lat[16]) ? 7'b0111111 : seg_tab[(m_lat >> (4 * d)) & 17'hF];
    end
    e_fd = fe;
    cur  = (m_mode == 1) ? req_a : req_b;
    oth  = (m_mode == 1) ? req_b : req_a;
    if (rst) begin
      m_mode = 0; m_t = 0; m_fr = 0; m_lat = '0;
      e_an = 4'hF; e_seg = 7'h7F; e_fd = 1'b0;
    end else if (m_mode == 0) begin
      if (req_a || req_b) begin
        m_mode = req_a ? 1 : 2; m_t = 0; m_fr = 0; m_lat = pick(m_mode);
      end
    end else if (fe) begin
      m_fr = (m_fr + 1 > HOLD) ? HOLD : m_fr + 1;
      m_t++;
      if (m_fr >= HOLD && oth) begin
        m_mode = 3 - m_mode; m_t = 0; m_fr = 0; m_lat = pick(m_mode);
      end else if (m_fr >= HOLD && !cur) begin
        m_mode = 0; m_t = 0; m_fr = 0;
      end else begin
        m_lat = pick(m_mode);
      end
    end else begin
      m_t++;
    end
    e_ga = (m_mode == 1);
    e_gb = (m_mode == 2);
    e_ok = 1'b1;
  end

  always @(negedge clk) begin
    if (e_ok) begin
      chk("gnt_a", gnt_a, e_ga);
      chk("gnt_b", gnt_b, e_gb);
      chk("an", an, e_an);
      chk("seg", seg, e_seg);
      chk("frame_done", frame_done, e_fd);
      chk("gnt_excl", gnt_a & gnt_b, 0);
    end
  end

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((gnt_a || gnt_b) && n < 200) begin @(negedge clk); n++; end
    chk(nm, gnt_a | gnt_b, 0);
  endtask

  logic [3:0] lit_an  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [6:0] lit_seg [4] = '{7'b0001110, 7'b0001000, 7'b0100100, 7'b1111001};

  initial begin
    int n;
    rst = 1; req_a = 0; req_b = 0; val_a = 0; val_b = 0; sign_a = 0; sign_b = 0;
    repeat (2) @(negedge clk);
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_gnt", {gnt_a, gnt_b}, 0);
    chk("rst_fd", frame_done, 0);
    rst = 0;
    @(negedge clk);

    // Scan order and hex encoding of 12AF.
    val_a = 16'h12AF; req_a = 1;
    @(negedge clk);
    chk("grant_a", gnt_a, 1);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("scan_an", an, lit_an[k / 4]);
      chk("scan_seg", seg, lit_seg[k / 4]);
      chk("scan_fd", frame_done, (k == 15) ? 1 : 0);
    end
    req_a = 0;
    val_a = 16'h3333;
    wait_idle("release_a");

    // Negative flag replaces digit 3 only.
    val_a = 16'h12AF; sign_a = 1; req_a = 1;
    @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k >= 12) chk("minus", seg, 7'b0111111);
      else if (k < 4) chk("neg_d0", seg, 7'b0001110);
    end
    req_a = 0; sign_a = 0;
    wait_idle("release_neg");

    // Both requesting: two frames each, round-robin.
    req_a = 1; req_b = 1;
    @(negedge clk);
    n = 0;
    while (gnt_a && n < 100) begin @(negedge clk); n++; end
    chk("hold_a_len", n, 2 * FRAME);
    chk("switch_b", gnt_b, 1);
    n = 0;
    while (gnt_b && n < 100) begin @(negedge clk); n++; end
    chk("hold_b_len", n, 2 * FRAME);
    chk("switch_a", gnt_a, 1);
    req_a = 0; req_b = 0;
    wait_idle("release_both");

    // Reset mid-frame while B is shown.
    req_b = 1;
    repeat (6) @(negedge clk);
    chk("b_shown", gnt_b, 1);
    rst = 1;
    @(negedge clk);
    chk("mid_rst_gnt", gnt_b, 0);
    chk("mid_rst_an", an, 4'hF);
    chk("mid_rst_seg", seg, 7'h7F);
    rst = 0; req_b = 0; req_a = 1;
    @(negedge clk);
    chk("post_rst_gnt", gnt_a, 1);
    @(negedge clk);
    chk("post_rst_idx0", an, 4'b1110);
    req_a = 0;

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(7) == 0) req_a = ~req_a;
      if ($urandom_range(7) == 0) req_b = ~req_b;
      if ($urandom_range(3) == 0) val_a = 16'($urandom);
      if ($urandom_range(3) == 0) val_b = 16'($urandom);
      if ($urandom_range(9) == 0) sign_a = ~sign_a;
      if ($urandom_range(9) == 0) sign_b = ~sign_b;
      rst = ($urandom_range(499) == 0);
      @(negedge clk);
    end
    rst = 0;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/disp_arbiter.md
DISP_ARBITER -- requirements
Module: disp_arbiter

Interface
REQ-001 The block SHALL have parameter DIV, default 50000, setting clk cycles per digit-scan tick (DIV >= 2).
REQ-002 The block SHALL have parameter HOLD, default 8, setting the minimum complete frames a grant is held (HOLD >= 1); a frame is 4 ticks.
REQ-003 The block SHALL have port clk  input  1  system clock, sole clock domain.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have ports req_a / req_b  input  1 each  display request from requester A / B.
REQ-006 The block SHALL have ports val_a / val_b  input  16 each  four hex digits, digit 0 in bits [3:0].
REQ-007 The block SHALL have ports sign_a / sign_b  input  1 each  negative flag.
REQ-008 The block SHALL have ports gnt_a / gnt_b  output  1 each  grant, registered, never both high.
REQ-009 The block SHALL have port an  output  4  one-hot active-low digit enable.
REQ-010 The block SHALL have port seg  output  7  active-low segments, bit 0 = top, bits 1..6 clockwise then middle.
REQ-011 The block SHALL have port frame_done  output  1  one-cycle pulse at end of each frame while granted.

Function
REQ-012 A prescaler SHALL count 0..DIV-1 and wrap; tick is the cycle the count equals DIV-1.
REQ-013 Scan index SHALL advance 0->1->2->3->0 on each tick; a frame ends on the tick where index 3 advances to 0.
REQ-014 The FSM SHALL have states IDLE, SHOW_A, SHOW_B.
REQ-015 IDLE: on any clk cycle with a request, the FSM SHALL enter SHOW_A (req_a high) or SHOW_B (only req_b high) on the next edge, with the grant high from that edge; prescaler and scan index SHALL reset to 0 on entry.
REQ-016 On grant and at every frame end, the block SHALL snapshot the granted requester's value and sign into an internal 17-bit latch; the display SHALL show only latched data.
REQ-017 A hold counter SHALL clear on grant and increment at each frame end, saturating at HOLD.
REQ-018 At a frame end with hold count >= HOLD (after increment): if the other requester is high, the grant SHALL switch to it (round-robin); else if the current requester is low, the FSM SHALL return to IDLE; else the grant SHALL remain.
REQ-019 Grant changes SHALL occur only at frame ends (or from IDLE); a request dropped mid-hold SHALL NOT release early.
REQ-020 On a switch, the old grant SHALL drop and the new grant rise on the same edge; latch, hold counter, prescaler and scan index SHALL reload/clear on that edge.
REQ-021 In IDLE, an SHALL be 4'b1111 and seg 7'b1111111.
REQ-022 While granted, an SHALL assert only bit [index] low; seg SHALL be the hex encoding of latched digit [index]: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-023 If the latched sign is 1, digit 3 SHALL display 0111111 (minus) in place of its hex value.
REQ-024 an and seg SHALL be registered and update together, one clk after index change.
REQ-025 frame_done SHALL pulse high for exactly one cycle at each frame end in SHOW_A/SHOW_B, including the frame end causing a switch or release.

Reset
REQ-026 With rst high at a clk edge, the block SHALL go to IDLE and clear prescaler, scan index, hold counter and latch; gnt_a=0, gnt_b=0, an=1111, seg=1111111, frame_done=0.
REQ-027 Reset SHALL override all other events, including a frame end on the same edge; outputs SHALL be valid reset values on the first edge with rst high.

Verification
REQ-028 DIV=4, HOLD=2; req_a=1, val_a=16'h12AF, sign_a=0 from IDLE -> gnt_a next edge; an cycles 1110,1101,1011,0111 every 4 clk; seg 0001110,0001000,0100100,1111001.
REQ-029 Same with sign_a=1 -> digit 3 seg = 0111111, digits 0-2 unchanged.
REQ-030 req_a and req_b held high -> gnt_a for exactly 2 frames, then gnt_b for 2 frames, then gnt_a; never both high; frame_done each frame.
REQ-031 req_a pulsed 1 cycle -> gnt_a held 2 frames, then IDLE with an=1111; val_a changed mid-frame appears only after next frame end.
REQ-032 rst asserted mid-frame in SHOW_B -> next edge gnt_b=0, an=1111, seg=1111111; req_a after rst release -> gnt_a with index 0.
